// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - control/memory/datapath signal bundle for the fetch stage
interface instr_fetch_unit_if;
   logic        fetch_req;
   logic        pc_write;
   logic [1:0]  pc_sel;
   logic [31:0] pc_ext;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        fetch_busy;
   logic        fetch_done;
   logic [31:0] ir;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic [25:0] addr26;
   logic [31:0] pc;
   logic        fault;

   modport master (
      input  fetch_req, pc_write, pc_sel, pc_ext, mem_rdata,
      output mem_addr, mem_rd, fetch_busy, fetch_done, ir, opcode, funct,
             rs, rt, rd, shamt, imm16, addr26, pc, fault
   );

   modport slave (
      output fetch_req, pc_write, pc_sel, pc_ext, mem_rdata,
      input  mem_addr, mem_rd, fetch_busy, fetch_done, ir, opcode, funct,
             rs, rt, rd, shamt, imm16, addr26, pc, fault
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle MIPS fetch stage: PC, timed memory read, IR and field split
// Optional MISALIGN_TRAP_EN: a fetch from an unaligned PC enters an absorbing FAULT state.
module instr_fetch_unit #(
   parameter int          MEM_LAT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic               clk,
   input logic               reset,
   instr_fetch_unit_if.master bus
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, READ, DONE, FAULT} state_t;

   state_t        state;
   logic [31:0]   pcReg;
   logic [31:0]   irReg;
   logic [CW-1:0] cnt;
   logic          memRd;
   logic          busy;
   logic          done;
   logic [31:0]   nextPc;
   logic          trap;

   // Branch/jump targets are relative to the already-incremented PC.
   always_comb begin
      nextPc = pcReg;
      case (bus.pc_sel)
         2'b01:   nextPc = pcReg + {{14{irReg[15]}}, irReg[15:0], 2'b00};
         2'b10:   nextPc = {pcReg[31:28], irReg[25:0], 2'b00};
         2'b11:   nextPc = bus.pc_ext;
         default: nextPc = pcReg;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign trap         = (pcReg[1:0] != 2'b00);
   assign bus.mem_addr = pcReg;
   assign bus.fault    = (state == FAULT);
`else
   assign trap         = 1'b0;
   assign bus.mem_addr = {pcReg[31:2], 2'b00};
   assign bus.fault    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pcReg <= RESET_PC;
         irReg <= 32'h0;
         cnt   <= '0;
         memRd <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.pc_write) begin
                  pcReg <= nextPc;
               end else if (bus.fetch_req) begin
                  busy <= 1'b1;
                  if (trap) begin
                     state <= FAULT;
                  end else begin
                     state <= READ;
                     cnt   <= '0;
                     memRd <= 1'b1;
                  end
               end
            end
            READ: begin
               if (cnt == CW'(MEM_LAT - 1)) begin
                  irReg <= bus.mem_rdata;
                  pcReg <= pcReg + 32'd4;
                  memRd <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.pc_write) pcReg <= nextPc;
               busy  <= 1'b0;
               state <= IDLE;
            end
            FAULT: begin
               busy <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_rd     = memRd;
   assign bus.fetch_busy = busy;
   assign bus.fetch_done = done;
   assign bus.pc         = pcReg;
   assign bus.ir         = irReg;
   assign bus.opcode     = irReg[31:26];
   assign bus.rs         = irReg[25:21];
   assign bus.rt         = irReg[20:16];
   assign bus.rd         = irReg[15:11];
   assign bus.shamt      = irReg[10:6];
   assign bus.funct      = irReg[5:0];
   assign bus.imm16      = irReg[15:0];
   assign bus.addr26     = irReg[25:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit (MISALIGN_TRAP_EN aware)
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.MEM_LAT(2), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] startPc;
      logic [31:0] word;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] adr;
      logic [31:0] pcAfter;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setPc(input logic [31:0] target);
      @(negedge clk);
      bus.pc_write = 1'b1;
      bus.pc_sel   = 2'b11;
      bus.pc_ext   = target;
      @(negedge clk);
      bus.pc_write = 1'b0;
      bus.pc_sel   = 2'b00;
   endtask

   // Cycle k=1 is the first cycle after the edge that samples fetch_req.
   task automatic doFetch(input bit wrInRead, input bit wrInDone, input logic [31:0] tgt,
                          output int rdCnt, output int doneAt, output logic [31:0] addrSeen);
      rdCnt    = 0;
      doneAt   = 0;
      addrSeen = 32'h0;
      @(negedge clk);
      bus.fetch_req = 1'b1;
      @(negedge clk);
      bus.fetch_req = 1'b0;
      for (int k = 1; k <= 10 && doneAt == 0; k++) begin
         if (bus.mem_rd) begin
            rdCnt++;
            addrSeen = bus.mem_addr;
         end
         if (bus.fetch_done) doneAt = k;
         bus.pc_write = (wrInRead && k == 1) || (wrInDone && bus.fetch_done);
         bus.pc_sel   = 2'b11;
         bus.pc_ext   = tgt;
         @(negedge clk);
      end
      bus.pc_write = 1'b0;
      bus.pc_sel   = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdCnt;
      int doneAt;
      int seen;
      logic [31:0] addrSeen;

      vecs[0] = '{32'h0000_0000, 32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 26'h12A4020, 32'h0000_0004};
      vecs[1] = '{32'h0000_0010, 32'h1000FFFF, 6'h04, 5'd0, 5'd0,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h000FFFF, 32'h0000_0014};
      vecs[2] = '{32'hFFFF_FFFC, 32'h8C220004, 6'h23, 5'd1, 5'd2,  5'd0,  5'd0,  6'h04, 16'h0004, 26'h0220004, 32'h0000_0000};
      vecs[3] = '{32'h0000_0400, 32'h08000100, 6'h02, 5'd0, 5'd0,  5'd0,  5'd4,  6'h00, 16'h0100, 26'h0000100, 32'h0000_0404};

      bus.fetch_req = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_sel    = 2'b00;
      bus.pc_ext    = 32'h0;
      bus.mem_rdata = 32'h0;

      repeat (2) @(negedge clk);
      check("reset_pc", bus.pc, 32'h0);
      check("reset_ir", bus.ir, 32'h0);
      check("reset_mem_rd", 32'(bus.mem_rd), 32'h0);
      check("reset_busy", 32'(bus.fetch_busy), 32'h0);
      check("reset_done", 32'(bus.fetch_done), 32'h0);
      check("reset_fault", 32'(bus.fault), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         setPc(vecs[i].startPc);
         bus.mem_rdata = vecs[i].word;
         doFetch(1'b0, 1'b0, 32'h0, rdCnt, doneAt, addrSeen);
         check($sformatf("v%0d_mem_addr", i), addrSeen, vecs[i].startPc);
         check($sformatf("v%0d_rd_cycles", i), 32'(rdCnt), 32'd2);
         check($sformatf("v%0d_done_cycle", i), 32'(doneAt), 32'd3);
         check($sformatf("v%0d_ir", i), bus.ir, vecs[i].word);
         check($sformatf("v%0d_opcode", i), 32'(bus.opcode), 32'(vecs[i].op));
         check($sformatf("v%0d_rs", i), 32'(bus.rs), 32'(vecs[i].rs));
         check($sformatf("v%0d_rt", i), 32'(bus.rt), 32'(vecs[i].rt));
         check($sformatf("v%0d_rd", i), 32'(bus.rd), 32'(vecs[i].rd));
         check($sformatf("v%0d_shamt", i), 32'(bus.shamt), 32'(vecs[i].sh));
         check($sformatf("v%0d_funct", i), 32'(bus.funct), 32'(vecs[i].fn));
         check($sformatf("v%0d_imm16", i), 32'(bus.imm16), 32'(vecs[i].imm));
         check($sformatf("v%0d_addr26", i), 32'(bus.addr26), 32'(vecs[i].adr));
         check($sformatf("v%0d_pc", i), bus.pc, vecs[i].pcAfter);
         check($sformatf("v%0d_busy_after", i), 32'(bus.fetch_busy), 32'h0);
      end

      // Branch by -1 word from the incremented PC, then jump into region 0.
      setPc(32'h10);
      bus.mem_rdata = 32'h1000FFFF;
      doFetch(1'b0, 1'b0, 32'h0, rdCnt, doneAt, addrSeen);
      check("t3_pc_after_fetch", bus.pc, 32'h14);
      bus.pc_write = 1'b1;
      bus.pc_sel   = 2'b01;
      @(negedge clk);
      bus.pc_write = 1'b0;
      check("t3_branch_pc", bus.pc, 32'h10);
      bus.mem_rdata = 32'h08000100;
      doFetch(1'b0, 1'b0, 32'h0, rdCnt, doneAt, addrSeen);
      bus.pc_write = 1'b1;
      bus.pc_sel   = 2'b10;
      @(negedge clk);
      bus.pc_write = 1'b0;
      bus.pc_sel   = 2'b00;
      check("t3_jump_pc", bus.pc, 32'h400);

      setPc(32'h100);
      bus.mem_rdata = 32'h0;
      doFetch(1'b1, 1'b0, 32'h80, rdCnt, doneAt, addrSeen);
      check("t5_read_write_ignored_pc", bus.pc, 32'h104);
      check("t5_read_write_addr", addrSeen, 32'h100);

      setPc(32'h200);
      doFetch(1'b0, 1'b1, 32'h3000, rdCnt, doneAt, addrSeen);
      check("done_write_pc", bus.pc, 32'h3000);

      // pc_write wins over fetch_req in IDLE.
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.pc_write  = 1'b1;
      bus.pc_sel    = 2'b11;
      bus.pc_ext    = 32'h44;
      @(negedge clk);
      bus.fetch_req = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_sel    = 2'b00;
      check("prio_mem_rd", 32'(bus.mem_rd), 32'h0);
      check("prio_pc", bus.pc, 32'h44);
      @(negedge clk);
      check("prio_busy", 32'(bus.fetch_busy), 32'h0);

      // Reset in the middle of a read.
      setPc(32'h20);
      bus.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.fetch_req = 1'b1;
      @(negedge clk);
      bus.fetch_req = 1'b0;
      check("t1_mem_rd_before", 32'(bus.mem_rd), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("t1_mem_rd", 32'(bus.mem_rd), 32'h0);
      check("t1_pc", bus.pc, 32'h0);
      check("t1_ir", bus.ir, 32'h0);
      seen = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (bus.fetch_done) seen++;
         @(negedge clk);
      end
      check("t1_no_done", 32'(seen), 32'h0);
      check("t1_ir_after", bus.ir, 32'h0);

      setPc(32'h6);
`ifdef MISALIGN_TRAP_EN
      seen = 0;
      @(negedge clk);
      bus.fetch_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.mem_rd) seen++;
      end
      bus.pc_write = 1'b1;
      bus.pc_sel   = 2'b11;
      bus.pc_ext   = 32'h0;
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_rd) seen++;
      end
      bus.fetch_req = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_sel    = 2'b00;
      check("t6_fault", 32'(bus.fault), 32'h1);
      check("t6_no_mem_rd", 32'(seen), 32'h0);
      check("t6_busy", 32'(bus.fetch_busy), 32'h1);
      check("t6_pc_held", bus.pc, 32'h6);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_fault_cleared", 32'(bus.fault), 32'h0);
`else
      check("t6_aligned_addr", bus.mem_addr, 32'h4);
      doFetch(1'b0, 1'b0, 32'h0, rdCnt, doneAt, addrSeen);
      check("t6_fetch_addr", addrSeen, 32'h4);
      check("t6_pc_after", bus.pc, 32'hA);
      check("t6_fault", 32'(bus.fault), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
